// File: rtl/func_seq_pkg.sv
// Shared types for the func_seq beat sequencer: function codes, beats,
// FSM states and the action strobe bundle.
package func_seq_pkg;

  localparam int FW = 3;

  typedef logic [FW-1:0] fcode_t;

  localparam fcode_t F_JMP  = 3'd0;
  localparam fcode_t F_JRP  = 3'd1;
  localparam fcode_t F_LDN  = 3'd2;
  localparam fcode_t F_STO  = 3'd3;
  localparam fcode_t F_SUB  = 3'd4;
  localparam fcode_t F_SUB2 = 3'd5;
  localparam fcode_t F_CMP  = 3'd6;
  localparam fcode_t F_STOP = 3'd7;

  typedef logic [1:0] beat_t;

  localparam beat_t B_SCAN1  = 2'd0;
  localparam beat_t B_SCAN2  = 2'd1;
  localparam beat_t B_DECODE = 2'd2;
  localparam beat_t B_ACTION = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN1,
    S_SCAN2,
    S_DECODE,
    S_ACTION
  } state_t;

  typedef struct packed {
    logic ci_load;
    logic ci_add;
    logic acc_ldn;
    logic acc_sub;
    logic st_write;
    logic ci_inc;
  } act_t;

  function automatic beat_t beat_of(state_t s);
    beat_t b;
    b = B_SCAN1;
    unique case (s)
      S_SCAN2:  b = B_SCAN2;
      S_DECODE: b = B_DECODE;
      S_ACTION: b = B_ACTION;
      default:  b = B_SCAN1;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/func_seq_if.sv
// Staticisor rails, run/key inputs and strobe outputs of func_seq.
// kcc exists only when SINGLE_STEP_EN is defined.
interface func_seq_if #(
  parameter int W = 3
);

  logic [0:W-1] i1;
  logic [0:W-1] i0;
  logic         run;
  logic         acc_neg;
`ifdef SINGLE_STEP_EN
  logic         kcc;
`endif
  logic [1:0]   beat;
  logic         ci_inc;
  logic         pi_load;
  logic         ci_load;
  logic         ci_add;
  logic         acc_ldn;
  logic         acc_sub;
  logic         st_write;
  logic         halt;
  logic         rail_err;

  modport master (
`ifdef SINGLE_STEP_EN
    output kcc,
`endif
    output i1, i0, run, acc_neg,
    input  beat, ci_inc, pi_load, ci_load, ci_add,
    input  acc_ldn, acc_sub, st_write, halt, rail_err
  );

  modport slave (
`ifdef SINGLE_STEP_EN
    input  kcc,
`endif
    input  i1, i0, run, acc_neg,
    output beat, ci_inc, pi_load, ci_load, ci_add,
    output acc_ldn, acc_sub, st_write, halt, rail_err
  );

endinterface

// File: rtl/func_seq_decode.sv
// Combinational map from function code and accumulator sign to the
// one-hot ACTION strobes.
module func_decode
  import func_seq_pkg::*;
(
  input  fcode_t f,
  input  logic   acc_neg,
  output act_t   act
);

  always_comb begin
    act = '0;
    unique case (1'b1)
      (f == F_JMP):  act.ci_load  = 1'b1;
      (f == F_JRP):  act.ci_add   = 1'b1;
      (f == F_LDN):  act.acc_ldn  = 1'b1;
      (f == F_STO):  act.st_write = 1'b1;
      (f == F_SUB),
      (f == F_SUB2): act.acc_sub  = 1'b1;
      (f == F_CMP):  act.ci_inc   = acc_neg;
      default: ;
    endcase
  end

endmodule

// File: rtl/func_seq.sv
// Four-beat instruction sequencer (SCAN1/SCAN2/DECODE/ACTION).
// Optional single-step key under SINGLE_STEP_EN.
module func_seq
  import func_seq_pkg::*;
#(
  parameter int INSTR_F_BITS = 3
) (
  input logic       clk,
  input logic       rst,
  func_seq_if.slave bus
);

  state_t state;
  state_t nxt;
  beat_t  beat_q;
  beat_t  beat_d;
  fcode_t f_q;
  fcode_t f_in;
  logic   run_q;
  logic   err_q;
  logic   rail_bad;
  logic   run_rise;
  logic   kcc_rise;
  logic   step_q;
  act_t   dec;
  act_t   act;

  // Rails are indexed [0:N-1] with bit 0 as the code LSB.
  always_comb begin
    f_in     = '0;
    rail_bad = 1'b0;
    for (int k = 0; k < INSTR_F_BITS; k++) begin
      f_in[k]  = bus.i1[k];
      rail_bad = rail_bad | (bus.i1[k] == bus.i0[k]);
    end
  end

  assign run_rise = bus.run & ~run_q;

`ifdef SINGLE_STEP_EN
  logic kcc_q;
  logic step_d;

  assign kcc_rise = bus.kcc & ~kcc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kcc_q  <= 1'b1;
      step_q <= 1'b0;
    end else begin
      kcc_q  <= bus.kcc;
      step_q <= step_d;
    end
  end

  always_comb begin
    step_d = step_q;
    if (state == S_IDLE && !err_q) begin
      if (run_rise)      step_d = 1'b0;
      else if (kcc_rise) step_d = 1'b1;
    end
  end
`else
  assign kcc_rise = 1'b0;
  assign step_q   = 1'b0;
`endif

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:
        if (!err_q && (run_rise || kcc_rise))
          nxt = S_SCAN1;
      S_SCAN1:  nxt = S_SCAN2;
      S_SCAN2:  nxt = S_DECODE;
      S_DECODE: nxt = rail_bad ? S_IDLE : S_ACTION;
      S_ACTION:
        if (f_q == F_STOP || !bus.run || step_q)
          nxt = S_IDLE;
        else
          nxt = S_SCAN1;
      default:  nxt = S_IDLE;
    endcase
  end

  // beat keeps its last value while idle.
  assign beat_d = (nxt == S_IDLE) ? beat_q : beat_of(nxt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      beat_q <= B_SCAN1;
      f_q    <= '0;
      run_q  <= 1'b1;
      err_q  <= 1'b0;
    end else begin
      state  <= nxt;
      beat_q <= beat_d;
      run_q  <= bus.run;
      if (state == S_DECODE) begin
        f_q <= f_in;
        if (rail_bad) err_q <= 1'b1;
      end
    end
  end

  func_decode u_dec (
    .f       (f_q),
    .acc_neg (bus.acc_neg),
    .act     (dec)
  );

  assign act = (state == S_ACTION) ? dec : '0;

  assign bus.beat     = beat_q;
  assign bus.ci_inc   = (state == S_SCAN1) | act.ci_inc;
  assign bus.pi_load  = (state == S_SCAN2);
  assign bus.ci_load  = act.ci_load;
  assign bus.ci_add   = act.ci_add;
  assign bus.acc_ldn  = act.acc_ldn;
  assign bus.acc_sub  = act.acc_sub;
  assign bus.st_write = act.st_write;
  assign bus.halt     = (state == S_IDLE);
  assign bus.rail_err = err_q;

endmodule

// File: tb/tb_func_seq.sv
// Self-checking bench for func_seq with a per-beat strobe model.
// Build with SINGLE_STEP_EN defined to also exercise the kcc key.
module tb_func_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  func_seq_if #(.W(3)) bus ();

  func_seq #(.INSTR_F_BITS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int pass_n  = 0;
  int total_n = 0;

  // {ci_inc, pi_load, ci_load, ci_add, acc_ldn, acc_sub, st_write}
  logic [6:0] strb;
  assign strb = {bus.ci_inc, bus.pi_load, bus.ci_load, bus.ci_add,
                 bus.acc_ldn, bus.acc_sub, bus.st_write};

  function automatic logic [6:0] act_of(int f, logic neg);
    case (f)
      0:       return 7'b0010000;
      1:       return 7'b0001000;
      2:       return 7'b0000100;
      3:       return 7'b0000001;
      4, 5:    return 7'b0000010;
      6:       return neg ? 7'b1000000 : 7'b0000000;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [0:2] rail(logic [2:0] f);
    logic [0:2] r;
    for (int j = 0; j < 3; j++) r[j] = f[j];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_code(input logic [2:0] f);
    bus.i1 = rail(f);
    bus.i0 = ~rail(f);
  endtask

  task automatic start_run();
    bus.run = 1'b0;
    step();
    bus.run = 1'b1;
  endtask

  task automatic check_idle(input string nm, input logic [1:0] wb,
                            input logic we);
    total_n++;
    if (bus.halt !== 1'b1 || strb !== 7'd0 || bus.beat !== wb ||
        bus.rail_err !== we)
      $display("FAIL %s: halt=%b strobes=%b beat=%0d rail_err=%b, want halt=1 strobes=0000000 beat=%0d rail_err=%b",
               nm, bus.halt, strb, bus.beat, bus.rail_err, wb, we);
    else pass_n++;
  endtask

  // Next posedge must enter SCAN1; returns with run set for ACTION exit.
  task automatic do_instr(input logic [2:0] f, input logic neg,
                          input logic keep);
    logic [6:0] ex;
    set_code(f);
    bus.acc_neg = neg;
    for (int b = 0; b < 4; b++) begin
      step();
      ex = (b == 0) ? 7'h40 : (b == 1) ? 7'h20 :
           (b == 2) ? 7'h00 : act_of(int'(f), neg);
      total_n++;
      if (bus.beat !== 2'(b) || bus.halt !== 1'b0 || strb !== ex ||
          bus.rail_err !== 1'b0)
        $display("FAIL instr f=%0d beat%0d: beat=%0d halt=%b strobes=%b err=%b, want beat=%0d halt=0 strobes=%b err=0",
                 f, b, bus.beat, bus.halt, strb, bus.rail_err, b, ex);
      else pass_n++;
      bus.run = (b < 3) ? 1'($urandom_range(0, 1)) : keep;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.run = 1'b1;
    bus.acc_neg = 1'b0;
    set_code(3'd0);
`ifdef SINGLE_STEP_EN
    bus.kcc = 1'b0;
`endif
    repeat (2) step();
    check_idle("reset state", 2'd0, 1'b0);
    rst = 1'b0;
    repeat (4) step();
    check_idle("run held over reset", 2'd0, 1'b0);
  endtask

  task automatic test_run_start();
    start_run();
    do_instr(3'd2, 1'b0, 1'b1);
    do_instr(3'd1, 1'b0, 1'b0);
    step();
    check_idle("run drop exit", 2'd3, 1'b0);
  endtask

  task automatic test_skip();
    start_run();
    do_instr(3'd6, 1'b1, 1'b1);
    do_instr(3'd6, 1'b0, 1'b0);
    step();
    check_idle("skip exit", 2'd3, 1'b0);
  endtask

  task automatic test_stop();
    start_run();
    do_instr(3'd7, 1'($urandom_range(0, 1)), 1'b1);
    step();
    check_idle("stop", 2'd3, 1'b0);
    repeat (5) step();
    check_idle("stop with run held", 2'd3, 1'b0);
    start_run();
    do_instr(3'd0, 1'b0, 1'b0);
    step();
    check_idle("restart after stop", 2'd3, 1'b0);
  endtask

  task automatic test_random();
    logic [2:0] f;
    logic       keep;
    start_run();
    for (int n = 0; n < 30; n++) begin
      f    = 3'($urandom_range(0, 7));
      keep = ($urandom_range(0, 3) != 0);
      do_instr(f, 1'($urandom_range(0, 1)), keep);
      if (f == 3'd7 || !keep) begin
        step();
        check_idle("random exit", 2'd3, 1'b0);
        start_run();
      end
    end
    do_instr(3'd7, 1'b0, 1'b0);
    step();
    check_idle("random final stop", 2'd3, 1'b0);
  endtask

  task automatic test_reset_mid_action();
    start_run();
    set_code(3'd3);
    repeat (4) step();
    total_n++;
    if (strb !== 7'b0000001 || bus.beat !== 2'd3)
      $display("FAIL sto action: strobes=%b beat=%0d, want 0000001 beat=3",
               strb, bus.beat);
    else pass_n++;
    rst = 1'b1;
    #1;
    total_n++;
    if (strb !== 7'd0 || bus.halt !== 1'b1 || bus.beat !== 2'd0)
      $display("FAIL async reset: strobes=%b halt=%b beat=%0d, want 0000000 halt=1 beat=0",
               strb, bus.halt, bus.beat);
    else pass_n++;
    #2;
    rst = 1'b0;
    repeat (5) step();
    check_idle("no restart after reset", 2'd0, 1'b0);
  endtask

  task automatic test_single();
`ifdef SINGLE_STEP_EN
    bus.run = 1'b0;
    bus.kcc = 1'b0;
    step();
    bus.kcc = 1'b1;
    do_instr(3'd4, 1'($urandom_range(0, 1)), 1'b0);
    step();
    check_idle("single step", 2'd3, 1'b0);
    repeat (3) step();
    check_idle("kcc held", 2'd3, 1'b0);
    bus.kcc = 1'b0;
`endif
  endtask

  task automatic test_rail();
    start_run();
    bus.i1 = rail(3'b101);
    bus.i0 = rail(3'b101);
    repeat (3) step();
    total_n++;
    if (bus.beat !== 2'd2 || strb !== 7'd0)
      $display("FAIL rail decode beat: beat=%0d strobes=%b, want 2 0000000",
               bus.beat, strb);
    else pass_n++;
    step();
    check_idle("rail fault", 2'd2, 1'b1);
    set_code(3'd2);
    start_run();
    repeat (4) step();
    check_idle("rail locked", 2'd2, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check_idle("rail cleared by reset", 2'd0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_run_start();
    test_skip();
    test_stop();
    test_random();
    test_reset_mid_action();
    test_single();
    test_rail();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
